// File: rtl/frame_sum_accumulator_pkg.sv
// Shared types, default widths and channel-slicing helpers for the frame sum accumulator.
package frame_sum_accumulator_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  localparam int DEF_NUM_CH     = 3;
  localparam int DEF_LINE_SUM_W = 24;
  localparam int DEF_ACC_W      = 32;
  localparam int DEF_MAX_LINES  = 1024;
  localparam int DEF_SATURATE   = 1;

  // Width of a line counter able to hold the value max_lines itself.
  function automatic int cnt_width(input int max_lines);
    return $clog2(max_lines + 1);
  endfunction

  // LSB position of channel ch inside a packed multi-channel vector.
  function automatic int lane_lsb(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/frame_sum_accumulator_if.sv
// Line-sum input / frame-sum output bundle of the frame sum accumulator.
interface frame_sum_accumulator_if
  import frame_sum_accumulator_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int LINE_SUM_W = DEF_LINE_SUM_W,
  parameter int ACC_W      = DEF_ACC_W,
  parameter int CNT_W      = cnt_width(DEF_MAX_LINES)
);
  logic [CNT_W-1:0]             cfg_num_lines;
  logic                         in_valid;
  logic                         in_sof;
  logic [NUM_CH*LINE_SUM_W-1:0] in_sum;
  logic                         out_valid;
  logic [NUM_CH*ACC_W-1:0]      out_sum;
  logic [NUM_CH-1:0]            out_overflow;
  logic                         out_err;
  logic                         busy;
  logic [CNT_W-1:0]             line_cnt;

  // Producer of line sums / consumer of frame results.
  modport master (
    output cfg_num_lines, in_valid, in_sof, in_sum,
    input  out_valid, out_sum, out_overflow, out_err, busy, line_cnt
  );

  // The accumulator itself.
  modport slave (
    input  cfg_num_lines, in_valid, in_sof, in_sum,
    output out_valid, out_sum, out_overflow, out_err, busy, line_cnt
  );
endinterface

// File: rtl/frame_sum_accumulator_sat_acc_lane.sv
// One channel's add with carry detection, clamped or wrapped on overflow.
module sat_acc_lane
  import frame_sum_accumulator_pkg::*;
#(
  parameter int LINE_SUM_W = DEF_LINE_SUM_W,
  parameter int ACC_W      = DEF_ACC_W,
  parameter int SATURATE   = DEF_SATURATE
) (
  input  logic [ACC_W-1:0]      i_acc,
  input  logic [LINE_SUM_W-1:0] i_add,
  output logic [ACC_W-1:0]      o_acc,
  output logic                  o_ovf
);
  // One extra bit so the carry-out is visible.
  logic [ACC_W:0] w_wide;

  assign w_wide = {1'b0, i_acc} + (ACC_W+1)'(i_add);
  assign o_ovf  = w_wide[ACC_W];
  assign o_acc  = (w_wide[ACC_W] && (SATURATE != 0)) ? {ACC_W{1'b1}} : w_wide[ACC_W-1:0];

endmodule

// File: rtl/frame_sum_accumulator.sv
// Accumulates per-channel line sums over a frame of N lines and publishes the frame totals.
module frame_sum_accumulator
  import frame_sum_accumulator_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int LINE_SUM_W = DEF_LINE_SUM_W,
  parameter int ACC_W      = DEF_ACC_W,
  parameter int MAX_LINES  = DEF_MAX_LINES,
  parameter int SATURATE   = DEF_SATURATE
) (
  input logic                   CLK,
  input logic                   reset_n,
  frame_sum_accumulator_if.slave bus
);
  localparam int               CNT_W = cnt_width(MAX_LINES);
  localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_LINES);

  state_t            r_state;
  logic [ACC_W-1:0]  r_acc [NUM_CH];
  logic [NUM_CH-1:0] r_ovf;
  logic [CNT_W-1:0]  r_line_cnt;
  logic [CNT_W-1:0]  r_num_lines;
  logic [ACC_W-1:0]  r_out_sum [NUM_CH];
  logic [NUM_CH-1:0] r_out_ovf;
  logic              r_out_valid;
  logic              r_out_err;

  logic [ACC_W-1:0]  w_load [NUM_CH];
  logic [ACC_W-1:0]  w_sum [NUM_CH];
  logic [NUM_CH-1:0] w_lane_ovf;
  logic [CNT_W-1:0]  w_num_lines;
  logic [CNT_W-1:0]  w_cnt_inc;

  // A zero or out-of-range line count means "as many lines as the block supports".
  assign w_num_lines = ((bus.cfg_num_lines == '0) || (bus.cfg_num_lines > MAX_N)) ?
                       MAX_N : bus.cfg_num_lines;
  assign w_cnt_inc   = r_line_cnt + CNT_W'(1);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_lane
      assign w_load[gi] = ACC_W'(bus.in_sum[lane_lsb(gi, LINE_SUM_W) +: LINE_SUM_W]);

      sat_acc_lane #(
        .LINE_SUM_W (LINE_SUM_W),
        .ACC_W      (ACC_W),
        .SATURATE   (SATURATE)
      ) u_lane (
        .i_acc (r_acc[gi]),
        .i_add (bus.in_sum[lane_lsb(gi, LINE_SUM_W) +: LINE_SUM_W]),
        .o_acc (w_sum[gi]),
        .o_ovf (w_lane_ovf[gi])
      );

      assign bus.out_sum[lane_lsb(gi, ACC_W) +: ACC_W] = r_out_sum[gi];
    end
  endgenerate

  assign bus.out_valid    = r_out_valid;
  assign bus.out_overflow = r_out_ovf;
  assign bus.out_err      = r_out_err;
  assign bus.busy         = (r_state == ACCUM);
  assign bus.line_cnt     = r_line_cnt;

  // Frame FSM: start on sof, add each further line, publish on the Nth line.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_ovf       <= '0;
      r_line_cnt  <= '0;
      r_num_lines <= '0;
      r_out_ovf   <= '0;
      r_out_valid <= 1'b0;
      r_out_err   <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_acc[c]     <= '0;
        r_out_sum[c] <= '0;
      end
    end else begin
      r_out_valid <= 1'b0;
      r_out_err   <= 1'b0;
      if (bus.in_valid) begin
        if (bus.in_sof) begin
          // A sof inside a frame abandons the partial sums and flags it.
          if (r_state == ACCUM) begin
            r_out_err <= 1'b1;
          end
          for (int c = 0; c < NUM_CH; c++) begin
            r_acc[c] <= w_load[c];
          end
          r_ovf       <= '0;
          r_num_lines <= w_num_lines;
          if (w_num_lines == CNT_W'(1)) begin
            // Single-line frame completes on its own sof.
            for (int c = 0; c < NUM_CH; c++) begin
              r_out_sum[c] <= w_load[c];
            end
            r_out_ovf   <= '0;
            r_out_valid <= 1'b1;
            r_line_cnt  <= '0;
            r_state     <= IDLE;
          end else begin
            r_line_cnt <= CNT_W'(1);
            r_state    <= ACCUM;
          end
        end else if (r_state == IDLE) begin
          // Data without a frame start is dropped.
          r_out_err <= 1'b1;
        end else begin
          for (int c = 0; c < NUM_CH; c++) begin
            r_acc[c] <= w_sum[c];
          end
          r_ovf <= r_ovf | w_lane_ovf;
          if (w_cnt_inc == r_num_lines) begin
            for (int c = 0; c < NUM_CH; c++) begin
              r_out_sum[c] <= w_sum[c];
            end
            r_out_ovf   <= r_ovf | w_lane_ovf;
            r_out_valid <= 1'b1;
            r_line_cnt  <= '0;
            r_state     <= IDLE;
          end else begin
            r_line_cnt <= w_cnt_inc;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_sum_accumulator.sv
// Self-checking bench: a wide default instance plus saturating and wrapping 8-bit instances.
module tb_frame_sum_accumulator;
  import frame_sum_accumulator_pkg::*;

  localparam int M_CNT_W = cnt_width(1024);
  localparam int N_CNT_W = cnt_width(8);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  frame_sum_accumulator_if #(.NUM_CH(3), .LINE_SUM_W(24), .ACC_W(32), .CNT_W(M_CNT_W)) m_if ();
  frame_sum_accumulator_if #(.NUM_CH(2), .LINE_SUM_W(8), .ACC_W(8), .CNT_W(N_CNT_W)) s_if ();
  frame_sum_accumulator_if #(.NUM_CH(2), .LINE_SUM_W(8), .ACC_W(8), .CNT_W(N_CNT_W)) w_if ();

  frame_sum_accumulator #(.NUM_CH(3), .LINE_SUM_W(24), .ACC_W(32), .MAX_LINES(1024), .SATURATE(1))
    u_main (.CLK(clk), .reset_n(rst_n), .bus(m_if));
  frame_sum_accumulator #(.NUM_CH(2), .LINE_SUM_W(8), .ACC_W(8), .MAX_LINES(8), .SATURATE(1))
    u_sat (.CLK(clk), .reset_n(rst_n), .bus(s_if));
  frame_sum_accumulator #(.NUM_CH(2), .LINE_SUM_W(8), .ACC_W(8), .MAX_LINES(8), .SATURATE(0))
    u_wrap (.CLK(clk), .reset_n(rst_n), .bus(w_if));

  typedef struct {
    logic [95:0] sum;
    logic [2:0]  ovf;
  } exp_t;

  typedef struct {
    int cfg;
    int lines;
    int gap;
    int v0, v1, v2;
    logic [31:0] e0, e1, e2;
  } vec_t;

  exp_t q_m[$];
  exp_t q_s[$];
  exp_t q_w[$];
  exp_t e_m, e_s, e_w;
  int   m_valid_cyc[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  vec_t tbl[5];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag_unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got out_valid=1, expected no frame result", name);
  endtask

  function automatic logic [71:0] pack3(input int a, input int b, input int c);
    return {c[23:0], b[23:0], a[23:0]};
  endfunction

  // Scoreboard monitors: every out_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (m_if.out_valid === 1'b1) begin
      m_valid_cyc.push_back(cyc);
      if (q_m.size() == 0) flag_unexpected("main_unexpected_valid");
      else begin
        e_m = q_m.pop_front();
        check("main_sum", m_if.out_sum, e_m.sum);
        check("main_ovf", m_if.out_overflow, e_m.ovf);
      end
      $display("main frame done @%0d: sum=0x%0h ovf=%b", cyc, m_if.out_sum, m_if.out_overflow);
    end
  end

  always @(negedge clk) begin
    if (s_if.out_valid === 1'b1) begin
      if (q_s.size() == 0) flag_unexpected("sat_unexpected_valid");
      else begin
        e_s = q_s.pop_front();
        check("sat_sum", s_if.out_sum, e_s.sum);
        check("sat_ovf", s_if.out_overflow, e_s.ovf);
      end
      $display("sat  frame done @%0d: sum=0x%0h ovf=%b", cyc, s_if.out_sum, s_if.out_overflow);
    end
  end

  always @(negedge clk) begin
    if (w_if.out_valid === 1'b1) begin
      if (q_w.size() == 0) flag_unexpected("wrap_unexpected_valid");
      else begin
        e_w = q_w.pop_front();
        check("wrap_sum", w_if.out_sum, e_w.sum);
        check("wrap_ovf", w_if.out_overflow, e_w.ovf);
      end
      $display("wrap frame done @%0d: sum=0x%0h ovf=%b", cyc, w_if.out_sum, w_if.out_overflow);
    end
  end

  // One beat on the wide instance; returns 1 time unit after the capturing edge.
  task automatic drive_m(input logic v, input logic s, input logic [71:0] d);
    m_if.in_valid = v;
    m_if.in_sof   = s;
    m_if.in_sum   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_m();
    drive_m(1'b0, 1'b0, 72'({$urandom(), $urandom(), $urandom()}));
  endtask

  // One beat on both 8-bit instances with identical stimulus.
  task automatic drive_n(input logic v, input logic s, input logic [15:0] d);
    s_if.in_valid = v;  s_if.in_sof = s;  s_if.in_sum = d;
    w_if.in_valid = v;  w_if.in_sof = s;  w_if.in_sum = d;
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input logic [15:0] es, input logic [1:0] os,
                        input logic [15:0] ew, input logic [1:0] ow);
    exp_t e;
    e.sum = 96'(es); e.ovf = 3'(os); q_s.push_back(e);
    e.sum = 96'(ew); e.ovf = 3'(ow); q_w.push_back(e);
  endtask

  // Frame of identical lines on the 8-bit instances.
  task automatic nframe(input int cfg, input int nlines, input logic [15:0] d,
                        input logic [15:0] es, input logic [1:0] os,
                        input logic [15:0] ew, input logic [1:0] ow);
    s_if.cfg_num_lines = 4'(cfg);
    w_if.cfg_num_lines = 4'(cfg);
    for (int k = 1; k <= nlines; k++) begin
      if (k == nlines) push_n(es, os, ew, ow);
      drive_n(1'b1, k == 1, d);
      if (k < nlines) begin
        check("nar_line_cnt", s_if.line_cnt, 4'(k));
        check("nar_no_valid", w_if.out_valid, 1'b0);
      end else begin
        check("sat_valid", s_if.out_valid, 1'b1);
        check("wrap_valid", w_if.out_valid, 1'b1);
      end
    end
    drive_n(1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    exp_t e;
    int   d;

    tbl[0] = '{cfg: 4, lines: 4, gap: 0, v0: 10, v1: 20, v2: 30, e0: 40, e1: 80, e2: 120};
    tbl[1] = '{cfg: 3, lines: 3, gap: 2, v0: 10, v1: 20, v2: 30, e0: 30, e1: 60, e2: 90};
    tbl[2] = '{cfg: 1, lines: 1, gap: 0, v0: 7, v1: 0, v2: 0, e0: 7, e1: 0, e2: 0};
    tbl[3] = '{cfg: 2, lines: 2, gap: 1, v0: 24'hFFFFFF, v1: 1, v2: 5,
               e0: 32'h1FFFFFE, e1: 2, e2: 10};
    tbl[4] = '{cfg: 5, lines: 5, gap: 0, v0: 1000, v1: 0, v2: 3, e0: 5000, e1: 0, e2: 15};

    m_if.cfg_num_lines = '0; m_if.in_valid = 1'b0; m_if.in_sof = 1'b0; m_if.in_sum = '0;
    s_if.cfg_num_lines = '0; s_if.in_valid = 1'b0; s_if.in_sof = 1'b0; s_if.in_sum = '0;
    w_if.cfg_num_lines = '0; w_if.in_valid = 1'b0; w_if.in_sof = 1'b0; w_if.in_sum = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", m_if.out_valid, 1'b0);
    check("rst_out_err", m_if.out_err, 1'b0);
    check("rst_busy", m_if.busy, 1'b0);
    check("rst_line_cnt", m_if.line_cnt, 11'd0);
    check("rst_out_sum", m_if.out_sum, 96'd0);
    check("rst_out_ovf", m_if.out_overflow, 3'd0);
    check("rst_sat_sum", s_if.out_sum, 16'd0);
    rst_n = 1'b1;
    idle_m();

    // Table of single frames on the wide instance.
    for (int i = 0; i < 5; i++) begin
      m_if.cfg_num_lines = 11'(tbl[i].cfg);
      for (int k = 1; k <= tbl[i].lines; k++) begin
        if (k == tbl[i].lines) begin
          e.sum = {tbl[i].e2, tbl[i].e1, tbl[i].e0};
          e.ovf = 3'b000;
          q_m.push_back(e);
        end
        drive_m(1'b1, k == 1, pack3(tbl[i].v0, tbl[i].v1, tbl[i].v2));
        if (k < tbl[i].lines) begin
          check("tbl_busy", m_if.busy, 1'b1);
          check("tbl_line_cnt", m_if.line_cnt, 11'(k));
          check("tbl_no_valid", m_if.out_valid, 1'b0);
          for (int g = 0; g < tbl[i].gap; g++) begin
            idle_m();
            check("tbl_gap_line_cnt", m_if.line_cnt, 11'(k));
          end
        end else begin
          check("tbl_valid", m_if.out_valid, 1'b1);
          check("tbl_idle_after", m_if.busy, 1'b0);
          check("tbl_cnt_cleared", m_if.line_cnt, 11'd0);
        end
      end
    end

    // Non-sof beat while idle: dropped, error pulse, result held.
    drive_m(1'b1, 1'b0, pack3(1, 2, 3));
    check("idle_err_pulse", m_if.out_err, 1'b1);
    check("idle_err_busy", m_if.busy, 1'b0);
    check("idle_err_cnt", m_if.line_cnt, 11'd0);
    check("idle_err_sum_held", m_if.out_sum, {32'd15, 32'd0, 32'd5000});
    idle_m();
    check("idle_err_one_cycle", m_if.out_err, 1'b0);

    // sof at line 3 of a 4-line frame restarts the frame.
    m_if.cfg_num_lines = 11'd4;
    drive_m(1'b1, 1'b1, pack3(1, 1, 1));
    drive_m(1'b1, 1'b0, pack3(2, 2, 2));
    check("rs_cnt_before", m_if.line_cnt, 11'd2);
    drive_m(1'b1, 1'b1, pack3(5, 6, 7));
    check("rs_err_pulse", m_if.out_err, 1'b1);
    check("rs_cnt_restart", m_if.line_cnt, 11'd1);
    drive_m(1'b1, 1'b0, pack3(5, 6, 7));
    check("rs_err_cleared", m_if.out_err, 1'b0);
    drive_m(1'b1, 1'b0, pack3(5, 6, 7));
    e.sum = {32'd28, 32'd24, 32'd20}; e.ovf = 3'b000; q_m.push_back(e);
    drive_m(1'b1, 1'b0, pack3(5, 6, 7));
    check("rs_valid", m_if.out_valid, 1'b1);

    // Back-to-back frames; cfg changes mid-frame must be ignored.
    m_if.cfg_num_lines = 11'd4;
    drive_m(1'b1, 1'b1, pack3(1, 2, 3));
    m_if.cfg_num_lines = 11'd2;
    drive_m(1'b1, 1'b0, pack3(1, 2, 3));
    drive_m(1'b1, 1'b0, pack3(1, 2, 3));
    check("b2b_cfg_latched", m_if.out_valid, 1'b0);
    e.sum = {32'd12, 32'd8, 32'd4}; e.ovf = 3'b000; q_m.push_back(e);
    drive_m(1'b1, 1'b0, pack3(1, 2, 3));
    check("b2b_valid_a", m_if.out_valid, 1'b1);
    m_if.cfg_num_lines = 11'd4;
    drive_m(1'b1, 1'b1, pack3(100, 200, 300));
    check("b2b_sof_accepted", m_if.line_cnt, 11'd1);
    check("b2b_no_err", m_if.out_err, 1'b0);
    drive_m(1'b1, 1'b0, pack3(100, 200, 300));
    drive_m(1'b1, 1'b0, pack3(100, 200, 300));
    e.sum = {32'd1200, 32'd800, 32'd400}; e.ovf = 3'b000; q_m.push_back(e);
    drive_m(1'b1, 1'b0, pack3(100, 200, 300));
    check("b2b_valid_b", m_if.out_valid, 1'b1);
    idle_m();
    if (m_valid_cyc.size() >= 2) begin
      d = m_valid_cyc[m_valid_cyc.size()-1] - m_valid_cyc[m_valid_cyc.size()-2];
      check("b2b_spacing", 32'(d), 32'd4);
    end else begin
      check("b2b_pulse_count", 32'(m_valid_cyc.size()), 32'd2);
    end

    // Reset in the middle of a frame.
    m_if.cfg_num_lines = 11'd4;
    drive_m(1'b1, 1'b1, pack3(9, 9, 9));
    drive_m(1'b1, 1'b0, pack3(9, 9, 9));
    check("mr_cnt_before", m_if.line_cnt, 11'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_async_sum", m_if.out_sum, 96'd0);
    check("mr_async_busy", m_if.busy, 1'b0);
    check("mr_async_cnt", m_if.line_cnt, 11'd0);
    idle_m();
    idle_m();
    check("mr_no_valid", m_if.out_valid, 1'b0);
    rst_n = 1'b1;
    drive_m(1'b1, 1'b0, pack3(9, 9, 9));
    check("mr_tail_err", m_if.out_err, 1'b1);
    check("mr_tail_idle", m_if.busy, 1'b0);
    drive_m(1'b1, 1'b0, pack3(9, 9, 9));
    check("mr_tail_cnt", m_if.line_cnt, 11'd0);
    m_if.cfg_num_lines = 11'd1;
    e.sum = {32'd5, 32'd4, 32'd3}; e.ovf = 3'b000; q_m.push_back(e);
    drive_m(1'b1, 1'b1, pack3(3, 4, 5));
    check("mr_new_frame_valid", m_if.out_valid, 1'b1);
    idle_m();

    // 8-bit overflow: channel 0 carries, channel 1 must stay clean.
    s_if.cfg_num_lines = 4'd2;
    w_if.cfg_num_lines = 4'd2;
    drive_n(1'b1, 1'b1, {8'd10, 8'd200});
    check("ov_busy", s_if.busy, 1'b1);
    push_n({8'd30, 8'd255}, 2'b01, {8'd30, 8'd44}, 2'b01);
    drive_n(1'b1, 1'b0, {8'd20, 8'd100});
    check("ov_sat_valid", s_if.out_valid, 1'b1);
    check("ov_wrap_valid", w_if.out_valid, 1'b1);
    drive_n(1'b0, 1'b0, 16'h0);

    // Overflow flags start clean in the next frame.
    nframe(1, 1, {8'd6, 8'd5}, {8'd6, 8'd5}, 2'b00, {8'd6, 8'd5}, 2'b00);

    // Clamp holds at all-ones on channel 1 while wrap keeps counting.
    s_if.cfg_num_lines = 4'd3;
    w_if.cfg_num_lines = 4'd3;
    drive_n(1'b1, 1'b1, {8'd250, 8'd1});
    drive_n(1'b1, 1'b0, {8'd10, 8'd1});
    push_n({8'd255, 8'd3}, 2'b10, {8'd5, 8'd3}, 2'b10);
    drive_n(1'b1, 1'b0, {8'd1, 8'd1});
    check("clamp_valid", s_if.out_valid, 1'b1);
    drive_n(1'b0, 1'b0, 16'h0);

    // Line count 0 and above MAX_LINES both mean MAX_LINES (8).
    nframe(0, 8, {8'd2, 8'd1}, {8'd16, 8'd8}, 2'b00, {8'd16, 8'd8}, 2'b00);
    nframe(12, 8, {8'd0, 8'd3}, {8'd0, 8'd24}, 2'b00, {8'd0, 8'd24}, 2'b00);

    repeat (3) idle_m();
    check("main_queue_drained", 32'(q_m.size()), 32'd0);
    check("sat_queue_drained", 32'(q_s.size()), 32'd0);
    check("wrap_queue_drained", 32'(q_w.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
